joy_scan_ctrl: RTL and testbench

- Sequences the external serial joystick shift register: generates JOY_CLK and JOY_LOAD, deserialises a 26-slot frame, and maps bits into two 12-bit active-low joystick words.
- Filters the words by frame-to-frame debouncing and publishes them atomically to the arcade core and to the reset and multiboot logic.
- Sits in the top level between the board joystick pins and the core's I_JOYSTICK, I_PLAYER and I_COIN inputs.

---
 rtl/joy_pkg.sv | 55 +++++
 rtl/joy_clkgen.sv | 39 +++
 rtl/joy_scan_ctrl.sv | 131 +++++++++++++
 tb/tb_joy_scan_ctrl.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/joy_pkg.sv
// Shared constants, FSM states and slot-to-bit table
// for the serial joystick scanner.
package joy_pkg;

  localparam int JOY_SLOTS      = 26;
  localparam int JOY_FIRST_DATA = 2;
  localparam int JOY_W          = 12;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    SHIFT  = 2'd2,
    COMMIT = 2'd3
  } joy_state_e;

  // p2: 0 = player 1 word, 1 = player 2 word
  typedef struct packed {
    logic       p2;
    logic [3:0] idx;
  } joy_map_t;

  function automatic joy_map_t joy_map(input logic [4:0] slot);
    joy_map_t m;
    m = {1'b0, 4'd0};
    case (slot)
      5'd2:  m = {1'b0, 4'd8};
      5'd3:  m = {1'b0, 4'd6};
      5'd4:  m = {1'b0, 4'd5};
      5'd5:  m = {1'b0, 4'd4};
      5'd6:  m = {1'b0, 4'd3};
      5'd7:  m = {1'b0, 4'd2};
      5'd8:  m = {1'b0, 4'd1};
      5'd9:  m = {1'b0, 4'd0};
      5'd10: m = {1'b1, 4'd8};
      5'd11: m = {1'b1, 4'd6};
      5'd12: m = {1'b1, 4'd5};
      5'd13: m = {1'b1, 4'd4};
      5'd14: m = {1'b1, 4'd3};
      5'd15: m = {1'b1, 4'd2};
      5'd16: m = {1'b1, 4'd1};
      5'd17: m = {1'b1, 4'd0};
      5'd18: m = {1'b1, 4'd10};
      5'd19: m = {1'b1, 4'd11};
      5'd20: m = {1'b1, 4'd9};
      5'd21: m = {1'b1, 4'd7};
      5'd22: m = {1'b0, 4'd10};
      5'd23: m = {1'b0, 4'd11};
      5'd24: m = {1'b0, 4'd9};
      5'd25: m = {1'b0, 4'd7};
      default: m = {1'b0, 4'd0};
    endcase
    return m;
  endfunction

endpackage

// File: rtl/joy_clkgen.sv
// Shift-clock divider: toggles joy_clk every DIV clks
// and flags which edge each terminal count produces.
module joy_clkgen #(
  parameter int DIV = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_run,
  output logic o_joy_clk,
  output logic o_rise,
  output logic o_fall
);

  localparam logic [7:0] LAST = 8'(DIV - 1);

  logic [7:0] r_cnt;
  logic       r_clk;
  logic       w_tick;

  assign w_tick    = i_run && (r_cnt == LAST);
  assign o_rise    = w_tick && !r_clk;
  assign o_fall    = w_tick && r_clk;
  assign o_joy_clk = r_clk;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_clk <= 1'b0;
    end else if (i_clr || !i_run) begin
      r_cnt <= '0;
      r_clk <= 1'b0;
    end else begin
      r_cnt <= w_tick ? 8'd0 : r_cnt + 8'd1;
      if (w_tick) r_clk <= ~r_clk;
    end
  end

endmodule

// File: rtl/joy_scan_ctrl.sv
// Joystick shift-register scanner: loads, shifts 26 slots,
// debounces whole frames and publishes both words atomically.
module joy_scan_ctrl
  import joy_pkg::*;
#(
  parameter int DIV      = 16,
  parameter int DEBOUNCE = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             joy_data,
  output logic             joy_clk,
  output logic             joy_load,
  output logic [JOY_W-1:0] joystick1,
  output logic [JOY_W-1:0] joystick2,
  output logic             frame_done,
  output logic             update
);

  localparam logic [2:0] DB    = 3'(DEBOUNCE);
  localparam logic [4:0] LAST  = 5'(JOY_SLOTS - 1);
  localparam logic [4:0] FIRST = 5'(JOY_FIRST_DATA);

  joy_state_e         r_state;
  logic [4:0]         r_slot;
  logic [JOY_W-1:0]   r_s1;
  logic [JOY_W-1:0]   r_s2;
  logic [2*JOY_W-1:0] r_prev;
  logic [2:0]         r_mcnt;

  logic               w_run;
  logic               w_clr;
  logic               w_rise;
  logic               w_fall;
  joy_map_t           w_map;
  logic [2*JOY_W-1:0] w_frame;
  logic               w_same;
  logic [2:0]         w_mnext;
  logic               w_pub;

  assign w_run = (r_state != IDLE);
  assign w_clr = enable &&
                 (r_state == IDLE || r_state == COMMIT);

  joy_clkgen #(.DIV(DIV)) u_clkgen (
    .clk       (clk),
    .rst_n     (reset_n),
    .i_clr     (w_clr),
    .i_run     (w_run),
    .o_joy_clk (joy_clk),
    .o_rise    (w_rise),
    .o_fall    (w_fall)
  );

  assign joy_load = (r_state != LOAD);
  assign w_map    = joy_map(r_slot);
  assign w_frame  = {r_s2, r_s1};
  assign w_same   = (w_frame == r_prev);

  // Run length of identical frames, saturating at DEBOUNCE
  always_comb begin
    w_mnext = 3'd1;
    if (w_same)
      w_mnext = (r_mcnt >= DB) ? DB : r_mcnt + 3'd1;
  end

  assign w_pub = (w_mnext == DB) &&
                 (w_frame != {joystick2, joystick1});

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_slot     <= '0;
      r_s1       <= '1;
      r_s2       <= '1;
      r_prev     <= '1;
      r_mcnt     <= '0;
      joystick1  <= '1;
      joystick2  <= '1;
      frame_done <= 1'b0;
      update     <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      update     <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (enable) begin
            r_state <= LOAD;
            r_slot  <= '0;
          end
        end
        LOAD: begin
          r_s1 <= '1;
          r_s2 <= '1;
          if (w_fall) begin
            r_slot  <= 5'd1;
            r_state <= SHIFT;
          end
        end
        SHIFT: begin
          if (w_rise && r_slot >= FIRST) begin
            if (w_map.p2) r_s2[w_map.idx] <= joy_data;
            else          r_s1[w_map.idx] <= joy_data;
          end
          if (w_fall) begin
            if (r_slot == LAST) begin
              r_slot  <= '0;
              r_state <= COMMIT;
            end else begin
              r_slot <= r_slot + 5'd1;
            end
          end
        end
        COMMIT: begin
          frame_done <= 1'b1;
          r_prev     <= w_frame;
          r_mcnt     <= w_mnext;
          if (w_pub) begin
            joystick1 <= r_s1;
            joystick2 <= r_s2;
            update    <= 1'b1;
          end
          r_state <= enable ? LOAD : IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_joy_scan_ctrl.sv
// Bench: two scanners (DEBOUNCE 1 and 2) fed by one serial
// joystick model, checked against a frame-level reference.
module tb_joy_scan_ctrl;
  import joy_pkg::*;

  localparam int DIV = 2;
  localparam int PER = 52 * DIV + 1;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic        joy_data;
  logic        jc1, jl1, fd1, up1;
  logic        jc2, jl2, fd2, up2;
  logic [11:0] a1, a2, b1, b2;

  logic [25:0] pat = '1;
  int          bslot = 0;
  logic        jc_prev = 1'b0;
  int          cyc = 0;
  int          nupd1 = 0, nupd2 = 0, nfd = 0;
  int          ld_cur = 0, ld_last = 0;
  int          n_chk = 0, n_fail = 0;

  logic [23:0] hist[$];
  logic [23:0] m1 = '1, m2 = '1;
  int          last_fd = 0;
  int          pu1 = 0, pu2 = 0;

  always #5 clk = ~clk;

  joy_scan_ctrl #(.DIV(DIV), .DEBOUNCE(1)) u_db1 (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .joy_data(joy_data), .joy_clk(jc1), .joy_load(jl1),
    .joystick1(a1), .joystick2(a2),
    .frame_done(fd1), .update(up1)
  );

  joy_scan_ctrl #(.DIV(DIV), .DEBOUNCE(2)) u_db2 (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .joy_data(joy_data), .joy_clk(jc2), .joy_load(jl2),
    .joystick1(b1), .joystick2(b2),
    .frame_done(fd2), .update(up2)
  );

  // External shift register: slot 0 while loading,
  // advancing on every falling shift clock.
  assign joy_data = (bslot < 26) ? pat[bslot[4:0]] : 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!jl1) bslot = 0;
    else if (jc_prev && !jc1) bslot = bslot + 1;
    jc_prev = jc1;
    if (up1) nupd1 = nupd1 + 1;
    if (up2) nupd2 = nupd2 + 1;
    if (fd1) nfd = nfd + 1;
    if (!jl1) ld_cur = ld_cur + 1;
    else if (ld_cur != 0) begin
      ld_last = ld_cur;
      ld_cur  = 0;
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  function automatic logic [23:0] frame_of(input logic [25:0] p);
    logic [11:0] s1, s2;
    joy_map_t m;
    s1 = '1;
    s2 = '1;
    for (int s = 2; s < 26; s++) begin
      m = joy_map(5'(s));
      if (m.p2) s2[m.idx] = p[s];
      else      s1[m.idx] = p[s];
    end
    return {s2, s1};
  endfunction

  task automatic wait_slot(input int s);
    int k;
    k = 0;
    while (bslot != s && k < 300) begin
      @(negedge clk); #1;
      k++;
    end
    if (bslot != s) chk("slot_wait", 32'd0, 32'd1);
  endtask

  // Present pattern p for the frame in progress, wait for its
  // commit and compare both scanners with the reference.
  task automatic do_frame(input logic [25:0] p, input bit b2b);
    logic [23:0] f;
    int run, k, eu1, eu2;
    pat = p;
    k = 0;
    do begin
      @(negedge clk); #1;
      k++;
    end while (!fd1 && k < 400);
    if (!fd1) begin
      chk("frame_timeout", 32'd0, 32'd1);
      return;
    end
    f = frame_of(p);
    hist.push_back(f);
    run = 1;
    for (int i = hist.size() - 2; i >= 0 && run < 8; i--) begin
      if (hist[i] == f) run++;
      else break;
    end
    eu1 = (run >= 1 && f != m1) ? 1 : 0;
    if (eu1 != 0) m1 = f;
    eu2 = (run >= 2 && f != m2) ? 1 : 0;
    if (eu2 != 0) m2 = f;
    chk("db1_words", {8'd0, a2, a1}, {8'd0, m1});
    chk("db2_words", {8'd0, b2, b1}, {8'd0, m2});
    chk("db1_update", nupd1 - pu1, eu1);
    chk("db2_update", nupd2 - pu2, eu2);
    chk("load_len", ld_last, 2 * DIV);
    if (b2b) chk("frame_period", cyc - last_fd, PER);
    pu1 = nupd1;
    pu2 = nupd2;
    last_fd = cyc;
  endtask

  initial begin
    logic [25:0] p, q;
    int fd0, hi, lo;

    #23;
    chk("rst_words1", {8'd0, a2, a1}, 32'h00FF_FFFF);
    chk("rst_words2", {8'd0, b2, b1}, 32'h00FF_FFFF);
    chk("rst_pins", {30'd0, jc1, jl1}, 32'd1);
    chk("rst_pulses", {30'd0, fd1, up1}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    p = '1; p[9] = 1'b0;
    pat = p;
    @(negedge clk);
    enable = 1'b1;
    do_frame(p, 1'b0);
    chk("slot9_j1", a1, 12'hFFE);
    chk("slot9_j2", a2, 12'hFFF);

    q = '1; q[23] = 1'b0;
    do_frame(q, 1'b1);
    do_frame('1, 1'b1);
    do_frame(q, 1'b1);
    chk("glitch_hold", b1, 12'hFFF);
    do_frame(q, 1'b1);
    chk("db2_slot23", b1, 12'h7FF);

    for (int s = 2; s < 26; s++) begin
      p = '1; p[s] = 1'b0;
      do_frame(p, 1'b1);
      if (s == 18) chk("slot18_j2", a2, 12'hBFF);
    end

    p = '1;
    for (int i = 0; i < 16; i++) begin
      if ($urandom_range(0, 2) != 0) p = 26'($urandom);
      do_frame(p, 1'b1);
    end

    pat = '1;
    wait_slot(12);
    enable = 1'b0;
    do_frame('1, 1'b1);
    fd0 = nfd;
    hi = 0;
    lo = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk); #1;
      if (jc1) hi++;
      if (!jl1) lo++;
    end
    chk("idle_no_frames", nfd - fd0, 0);
    chk("idle_clk_low", hi, 0);
    chk("idle_load_high", lo, 0);

    enable = 1'b1;
    do_frame('0, 1'b0);
    do_frame('0, 1'b1);
    chk("zeros_out", {8'd0, b2, b1}, 32'd0);
    pat = '0;
    wait_slot(20);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst1", {8'd0, a2, a1}, 32'h00FF_FFFF);
    chk("async_rst2", {8'd0, b2, b1}, 32'h00FF_FFFF);
    chk("async_rst_load", {31'd0, jl1}, 32'd1);
    hist.delete();
    m1 = '1;
    m2 = '1;
    pat = '1;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk); #1;
    chk("load_after_rst", {31'd0, jl1}, 32'd0);
    pu1 = nupd1;
    pu2 = nupd2;

    do_frame('1, 1'b0);
    for (int i = 0; i < 9; i++) do_frame('1, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
